// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster-order pixel stream to registered 3x3 windows using two line buffers.
module conv_window_buffer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pixel_valid,
    input  logic [PIX_W-1:0]           pixel_in,
    output logic                       win_valid,
    output logic [9*PIX_W-1:0]         win_data,
    output logic [$clog2(IMG_W)-1:0]   col_idx,
    output logic [$clog2(IMG_H)-1:0]   row_idx,
    output logic                       frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic col_last, row_last;
    assign col_last = col_idx == CW'(IMG_W - 1);
    assign row_last = row_idx == RW'(IMG_H - 1);
    // Line buffers are plain RAM: never reset, only exposed behind win_valid.
    always_ff @(posedge clk)
        if (pixel_valid) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= pixel_in;
        end
    // Element (r,c) lives at PIX_W*(3r+c); each row shifts toward c0 and the new column enters c2.
    always_ff @(posedge clk)
        if (!rst) begin
            col_idx    <= '0;
            row_idx    <= '0;
            win_data   <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pixel_valid && row_idx >= RW'(2) && col_idx >= CW'(2);
            frame_done <= pixel_valid && row_last && col_last;
            if (pixel_valid) begin
                col_idx  <= col_last ? '0 : col_idx + 1'b1;
                row_idx  <= col_last ? (row_last ? '0 : row_idx + 1'b1) : row_idx;
                win_data <= {pixel_in, win_data[9*PIX_W-1:7*PIX_W],
                             lb0[col_idx], win_data[6*PIX_W-1:4*PIX_W],
                             lb1[col_idx], win_data[3*PIX_W-1:PIX_W]};
            end
        end
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: table-driven check of 4x4 and 5x3 window generators.
module tb_conv_window_buffer;
    typedef struct {
        logic [7:0]  p;
        logic        ev;
        logic [71:0] ew;
        logic        efd;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v4 = 1'b0, v5 = 1'b0;
    logic [7:0] p4 = '0, p5 = '0;
    logic wv4, wv5, fd4, fd5;
    logic [71:0] wd4, wd5;
    logic [1:0] c4, r4, r5;
    logic [2:0] c5;
    int nvec = 0;
    int nerr = 0;
    int ec[2] = '{0, 0};
    int er[2] = '{0, 0};
    string tag;
    vec_t t4[16];
    vec_t t5[15];
    always #5 clk = ~clk;
    conv_window_buffer #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u4 (
        .clk(clk), .rst(rst), .pixel_valid(v4), .pixel_in(p4), .win_valid(wv4),
        .win_data(wd4), .col_idx(c4), .row_idx(r4), .frame_done(fd4)
    );
    conv_window_buffer #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) u5 (
        .clk(clk), .rst(rst), .pixel_valid(v5), .pixel_in(p5), .win_valid(wv5),
        .win_data(wd5), .col_idx(c5), .row_idx(r5), .frame_done(fd5)
    );
    function automatic logic [71:0] w9(input int a, b, c, d, e, f, g, h, i);
        return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction
    function automatic logic [71:0] addoff(input logic [71:0] w, input int off);
        logic [71:0] r;
        for (int b = 0; b < 9; b++) r[8*b +: 8] = w[8*b +: 8] + 8'(off);
        return r;
    endfunction
    task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s %s: got %h, expected %h", tag, n, a, e);
        end
    endtask
    task automatic step(input bit sel, input logic v, input logic [7:0] p,
                        input logic ev, input logic [71:0] ew, input logic efd);
        int w, h;
        w = sel ? 5 : 4;
        h = sel ? 3 : 4;
        if (sel) begin v5 = v; p5 = p; end
        else begin v4 = v; p4 = p; end
        @(posedge clk);
        #1;
        v4 = 1'b0;
        v5 = 1'b0;
        if (v) begin
            ec[sel] = ec[sel] + 1;
            if (ec[sel] == w) begin
                ec[sel] = 0;
                er[sel] = (er[sel] + 1) % h;
            end
        end
        chk("win_valid", 72'(sel ? wv5 : wv4), 72'(ev));
        chk("frame_done", 72'(sel ? fd5 : fd4), 72'(efd));
        chk("col_idx", 72'(sel ? int'(c5) : int'(c4)), 72'(ec[sel]));
        chk("row_idx", 72'(sel ? int'(r5) : int'(r4)), 72'(er[sel]));
        if (ev) chk($sformatf("win_data after pixel %0d", p), sel ? wd5 : wd4, ew);
    endtask
    task automatic do_reset(input int n, input bit check_data);
        rst = 1'b0;
        v4 = 1'b0;
        v5 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        ec = '{0, 0};
        er = '{0, 0};
        chk("reset win_valid", 72'({wv4, wv5}), 72'(0));
        chk("reset frame_done", 72'({fd4, fd5}), 72'(0));
        chk("reset counters", 72'({c4, r4, c5, r5}), 72'(0));
        if (check_data) chk("reset win_data", {wd4 | wd5}, 72'(0));
        rst = 1'b1;
    endtask
    task automatic run_frame(input bit sel, input int off, input bit gaps);
        if (!sel) begin
            for (int k = 0; k < 16; k++) begin
                step(0, 1'b1, t4[k].p + 8'(off), t4[k].ev, addoff(t4[k].ew, off), t4[k].efd);
                if (gaps) step(0, 1'b0, 8'hEE, 1'b0, '0, 1'b0);
            end
        end else begin
            for (int k = 0; k < 15; k++)
                step(1, 1'b1, t5[k].p + 8'(off), t5[k].ev, addoff(t5[k].ew, off), t5[k].efd);
        end
    endtask
    initial begin
        for (int k = 0; k < 16; k++) t4[k] = '{8'(k + 1), 1'b0, 72'd0, k == 15};
        t4[10] = '{8'd11, 1'b1, w9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
        t4[11] = '{8'd12, 1'b1, w9(2, 3, 4, 6, 7, 8, 10, 11, 12), 1'b0};
        t4[14] = '{8'd15, 1'b1, w9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b0};
        t4[15] = '{8'd16, 1'b1, w9(6, 7, 8, 10, 11, 12, 14, 15, 16), 1'b1};
        for (int k = 0; k < 15; k++) t5[k] = '{8'(k + 1), 1'b0, 72'd0, k == 14};
        t5[12] = '{8'd13, 1'b1, w9(1, 2, 3, 6, 7, 8, 11, 12, 13), 1'b0};
        t5[13] = '{8'd14, 1'b1, w9(2, 3, 4, 7, 8, 9, 12, 13, 14), 1'b0};
        t5[14] = '{8'd15, 1'b1, w9(3, 4, 5, 8, 9, 10, 13, 14, 15), 1'b1};
        tag = "reset";
        do_reset(2, 1'b1);
        tag = "frame 1..16";
        run_frame(0, 0, 1'b0);
        tag = "frame 101..116";
        run_frame(0, 100, 1'b0);
        tag = "gapped frame";
        run_frame(0, 0, 1'b1);
        tag = "partial frame";
        for (int k = 0; k < 6; k++) step(0, 1'b1, t4[k].p, 1'b0, '0, 1'b0);
        tag = "mid-frame reset";
        do_reset(1, 1'b0);
        tag = "frame after reset";
        run_frame(0, 0, 1'b0);
        tag = "idle";
        step(0, 1'b0, 8'h55, 1'b0, '0, 1'b0);
        tag = "5x3 frame";
        run_frame(1, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
